// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and FSM encoding for the phase-shifting PWM block.
//   N_CH  : number of PWM channels
//   CNT_W : period counter / duty width (period = 2^CNT_W cycles)
//   CH_W  : channel index width
//   state_t : controller states IDLE / RUN / DRAIN
package pwm_pkg;
  localparam int N_CH  = 8;
  localparam int CNT_W = 8;
  localparam int CH_W  = $clog2(N_CH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;
endpackage

// File: rtl/pwm_channel_cmp.sv
// pwm_channel_cmp: one PWM channel; compares the shared period counter with
// the channel's selected duty and registers the result.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : controller busy; output forced low when 0
//   cnt        : shared period counter
//   duty       : high cycles per period for this output
//   pwm        : registered PWM output (one cycle after cnt)
module pwm_channel_cmp #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm
);
  import pwm_pkg::*;

  logic pwm_p1;

  // Stage p1: compare result registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_p1 <= 1'b0;
    else        pwm_p1 <= en && (cnt < duty);
  end

  assign pwm = pwm_p1;
endmodule

// File: rtl/pwm_shift_ctrl.sv
// pwm_shift_ctrl: N_CH-channel PWM generator with double-buffered duties and
// periodic phase rotation of the duty-to-output mapping.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (release synchronised)
//   en          : run enable
//   wr_valid/wr_ready, wr_ch, wr_duty : duty write handshake
//   shift_div   : periods per rotation step, 0 freezes rotation
//   pwm         : registered PWM outputs
//   period_tick : pulse on the last count of each running period
//   busy        : high while RUN or DRAIN
module pwm_shift_ctrl #(
  parameter int N_CH  = pwm_pkg::N_CH,
  parameter int CNT_W = pwm_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  input  logic [7:0]       shift_div,
  output logic [N_CH-1:0]  pwm,
  output logic             period_tick,
  output logic             busy
);
  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       rst_sync;
  logic             rst_int_n;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       pcnt;
  logic [CH_W-1:0]  rot;
  logic [CNT_W-1:0] shadow   [N_CH];
  logic [CNT_W-1:0] active   [N_CH];
  logic [CNT_W-1:0] duty_sel [N_CH];
  logic [CH_W-1:0]  sel_idx  [N_CH];
  logic             wrap, wr_fire, to_idle;

  // Assertion is immediate; release is delayed two edges so every flop
  // leaves reset on a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (!en) state_nx = DRAIN;
      DRAIN: begin
        if (en)                  state_nx = RUN;
        else if (cnt == CNT_MAX) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign wr_ready    = (state != DRAIN);
  assign wrap        = busy && (cnt == CNT_MAX);
  assign period_tick = wrap;
  assign wr_fire     = wr_valid && wr_ready;
  assign to_idle     = (state == DRAIN) && (state_nx == IDLE);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= busy ? cnt + 1'b1 : '0;
    end
  end

  // Rotation: pcnt counts finished periods; the compare against shift_div-1
  // lets a lowered divider take effect at the very next wrap.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pcnt <= '0;
      rot  <= '0;
    end else if (to_idle) begin
      pcnt <= '0;
      rot  <= '0;
    end else if (wrap && (shift_div != 8'd0)) begin
      if (pcnt >= shift_div - 8'd1) begin
        pcnt <= '0;
        rot  <= (int'(rot) == N_CH - 1) ? '0 : rot + 1'b1;
      end else begin
        pcnt <= pcnt + 8'd1;
      end
    end
  end

  // Shadow takes every accepted write; active follows shadow at the wrap,
  // with a same-cycle write bypassed so it is live from cnt=0.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_fire) shadow[wr_ch] <= wr_duty;
      if (wrap) begin
        for (int i = 0; i < N_CH; i++) active[i] <= shadow[i];
        if (wr_fire) active[wr_ch] <= wr_duty;
      end else if (wr_fire && (state == IDLE)) begin
        active[wr_ch] <= wr_duty;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sel_idx[i]  = CH_W'((i + int'(rot)) % N_CH);
      duty_sel[i] = active[sel_idx[i]];
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    pwm_channel_cmp #(.CNT_W(CNT_W)) u_cmp (
      .clk   (clk),
      .rst_n (rst_int_n),
      .en    (busy),
      .cnt   (cnt),
      .duty  (duty_sel[gi]),
      .pwm   (pwm[gi])
    );
  end
endmodule
